// File: rtl/sram_1rw_ctrl.sv
// sram_1rw_ctrl: single-port (1RW) memory with valid/ready requests and
// a credit-managed response FIFO; zero-fills the array after reset.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake; req_we selects write (1) / read (0)
//   req_addr          word address
//   req_wmask         per-lane write enable (ignored on reads)
//   req_wdata         write data
//   rsp_valid/ready   response handshake; rsp_rdata is the FIFO head
//   init_done         high once the zero-fill pass has completed
//   rsp_perr          per-lane parity error, only with SRAM_PARITY_EN
//
// Optional feature macro: SRAM_PARITY_EN (even parity per lane).
`timescale 1ns/1ps

module sram_1rw_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int LANE_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int RSP_DEPTH    = READ_LATENCY + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_we,
    input  logic [ADDR_WIDTH-1:0]              req_addr,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   req_wmask,
    input  logic [DATA_WIDTH-1:0]              req_wdata,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic                               init_done
`ifdef SRAM_PARITY_EN
    ,
    output logic [DATA_WIDTH/LANE_WIDTH-1:0]   rsp_perr
`endif
);

    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int CW        = $clog2(RSP_DEPTH + 1);
    localparam int PW        = $clog2(RSP_DEPTH);
`ifdef SRAM_PARITY_EN
    localparam int EW        = DATA_WIDTH + NUM_LANES;
`else
    localparam int EW        = DATA_WIDTH;
`endif
    localparam logic [CW-1:0] CREDIT_MAX = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(RSP_DEPTH - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  init_we;
    logic [CW-1:0]         credits;
    logic                  acc;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [EW-1:0]         rd_word;
    logic [EW-1:0]         push_word;
    logic [EW-1:0]         out_word;
    logic [EW-1:0]         hold_word;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef SRAM_PARITY_EN
    logic [NUM_LANES-1:0]  par_mem [DEPTH];
    logic [NUM_LANES-1:0]  rd_perr;
`endif

    logic [EW-1:0]         fifo [RSP_DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_INIT: if (init_addr == '1) state_next = S_RUN;
            S_RUN:  state_next = S_RUN;
            default: state_next = S_INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = 1'b0;
        init_done = 1'b0;
        init_we   = 1'b0;
        case (state)
            S_INIT: init_we = 1'b1;
            S_RUN: begin
                init_done = 1'b1;
                req_ready = (credits < CREDIT_MAX);
            end
            default: init_we = 1'b0;
        endcase
    end

    assign acc    = req_valid && req_ready;
    assign rd_acc = acc && !req_we;
    assign wr_acc = acc && req_we;
    assign pop    = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_addr <= '0;
        end else if (init_we) begin
            init_addr <= init_addr + 1'b1;
        end
    end

    // Credits cover both in-flight reads and buffered responses, so the
    // FIFO can never be asked to take more than it holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= '0;
        end else begin
            credits <= credits + CW'(rd_acc) - CW'(pop);
        end
    end

    // ---------------- array write port ----------------
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= '0;
`ifdef SRAM_PARITY_EN
            par_mem[init_addr] <= '0;
`endif
        end else if (wr_acc) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (req_wmask[i]) begin
                    mem[req_addr][i*LANE_WIDTH +: LANE_WIDTH] <=
                        req_wdata[i*LANE_WIDTH +: LANE_WIDTH];
`ifdef SRAM_PARITY_EN
                    par_mem[req_addr][i] <=
                        ^req_wdata[i*LANE_WIDTH +: LANE_WIDTH];
`endif
                end
            end
        end
    end

    // Array is sampled at the accepting edge, so later writes to the same
    // address cannot leak into an older read regardless of latency.
    always_comb begin
        rd_data = mem[req_addr];
`ifdef SRAM_PARITY_EN
        rd_perr = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            rd_perr[i] = par_mem[req_addr][i] ^
                         (^rd_data[i*LANE_WIDTH +: LANE_WIDTH]);
        end
        rd_word = {rd_perr, rd_data};
`else
        rd_word = rd_data;
`endif
    end

    // ---------------- read latency pipeline ----------------
    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign push      = rd_acc;
            assign push_word = rd_word;
        end else begin : g_latn
            logic [READ_LATENCY-2:0] pv;
            logic [EW-1:0]           pd [READ_LATENCY-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv <= '0;
                end else begin
                    pv[0] <= rd_acc;
                    for (int i = 1; i < READ_LATENCY - 1; i++) begin
                        pv[i] <= pv[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                pd[0] <= rd_word;
                for (int i = 1; i < READ_LATENCY - 1; i++) begin
                    pd[i] <= pd[i-1];
                end
            end

            assign push      = pv[READ_LATENCY-2];
            assign push_word = pd[READ_LATENCY-2];
        end
    endgenerate

    // ---------------- response FIFO ----------------
    assign rsp_valid = (count != '0);

    // When empty, present the value shown on the previous cycle so the
    // output holds its last data instead of exposing a stale slot.
    assign out_word = rsp_valid ? fifo[rptr] : hold_word;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wptr] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            hold_word <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + PW'(1);
            end
            count     <= count + CW'(push) - CW'(pop);
            hold_word <= out_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count == CREDIT_MAX));
        end
    end

`ifdef SRAM_PARITY_EN
    assign {rsp_perr, rsp_rdata} = out_word;
`else
    assign rsp_rdata = out_word;
`endif

endmodule

// File: doc/sram_1rw_ctrl.md
Name: sram_1rw_ctrl

Overview:
Parametrised single-port (1RW) on-chip memory with a valid/ready request port and a buffered response port. It generalises the fixed 32x512 macro model to any width, depth and mask granularity, with configurable read latency and response backpressure. After reset it zero-initialises its contents before accepting requests. It sits between the core/bus interconnect and instruction/data storage.

Parameters:
DATA_WIDTH, 32, data word width in bits; must be a multiple of LANE_WIDTH
ADDR_WIDTH, 9, word address width; DEPTH = 2**ADDR_WIDTH
LANE_WIDTH, 8, write-mask granularity in bits; NUM_LANES = DATA_WIDTH/LANE_WIDTH
READ_LATENCY, 1, cycles from read accept to data valid at the buffer input; legal range 1..4
RSP_DEPTH, READ_LATENCY+1, response buffer entries; must be >= READ_LATENCY+1

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wmask  in  NUM_LANES  per-lane write enable; ignored on reads
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  read data valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_WIDTH  read data
init_done  out  1  high once zero-initialisation completes

Behaviour:
- Reset (rst high at a rising edge): req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, credit counter=0, response buffer emptied, in-flight reads discarded. Reset in mid-operation or mid-init aborts the operation, and init restarts from address 0.
- FSM states: INIT and RUN.
- INIT: writes all-zero to address 0..DEPTH-1, one address per cycle; takes exactly DEPTH cycles after rst falls. req_ready=0 throughout. On the final address, move to RUN, and init_done rises on the next cycle.
- RUN: req_ready = (credits < RSP_DEPTH). Credits = in-flight reads + buffered responses.
  - Credits increment on read accept and decrement on response pop. Both in one cycle leaves credits unchanged.
  - Writes do not consume credits, but they are gated by the same req_ready.
- Write: lanes with req_wmask[i]=1 update bits [i*LANE_WIDTH +: LANE_WIDTH] at the accepting edge. Other lanes keep their value. A mask of all zero is a legal no-op. Writes produce no response.
- Read: data for req_addr enters the response buffer READ_LATENCY cycles after accept.
  - With an empty buffer and READ_LATENCY=1, rsp_valid is high on the cycle after accept.
  - Reads return data in accept order.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- Response buffer: FIFO of RSP_DEPTH entries with head on rsp_rdata.
  - rsp_valid is high while the FIFO is non-empty.
  - rsp_rdata holds its value while rsp_valid && !rsp_ready.
  - When empty, rsp_rdata holds its last value.
  - The credit scheme guarantees no overflow; overflow is an assertion failure.
- Back-to-back: with rsp_ready tied high, one read per cycle is sustained indefinitely.
- Addresses wrap naturally: there is no out-of-range address.
- Reads in INIT or while req_ready=0 are not accepted, and the requester must hold its request.

Optional Feature:
SRAM_PARITY_EN
- Defined: the array stores one even-parity bit per lane, computed on write (INIT writes parity 0). On read, parity is rechecked and output port rsp_perr (out, NUM_LANES) flags mismatching lanes, aligned with rsp_rdata and qualified by rsp_valid. The bench injects errors with a hierarchical force of a stored parity bit.
- Undefined: there is no parity storage and no rsp_perr port.

Test Plan:
- Init: release rst with DEPTH=512 -> req_ready=0 for 512 cycles, init_done=1 on cycle 513; read addr 0x1FF -> rsp_rdata=0x00000000.
- Masked write: write 0xDEADBEEF mask 4'b1111 to 0x010, then 0x11223344 mask 4'b0101 -> read 0x010 returns 0xDE22BE44.
- Latency/throughput: READ_LATENCY=2, rsp_ready=1, read addrs 0..7 on consecutive cycles -> 8 responses in order on consecutive cycles, first 2 cycles after the first accept.
- Backpressure: rsp_ready=0, issue reads continuously -> exactly RSP_DEPTH accepted, then req_ready=0. Raise rsp_ready -> data drains in order, and rsp_rdata is stable while stalled.
- Reset mid-stream: assert rst with 2 reads in flight -> rsp_valid=0 next cycle, the old responses never appear, and init reruns (512 cycles).
- SRAM_PARITY_EN: write 0x000000FF to 0x020, force lane-0 parity bit flipped -> read returns rsp_perr=4'b0001 with rsp_rdata=0x000000FF.
